// File: rtl/bus_arbiter_if.sv
// Simple request/response bus shared by the instruction-fetch and load/store leaders
// and the system bus; the leader drives requests, the follower returns read data.
interface bus;
  logic        read_req;
  logic        write_req;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [3:0]  byte_enable;
  logic [31:0] read_data;
  logic        read_data_valid;

  // Handshake: a request is a one-cycle read_req or write_req pulse with addr/data
  // valid in that same cycle; read_data is meaningful only while read_data_valid is high.
  modport leader (
    output read_req, write_req, addr, write_data, byte_enable,
    input  read_data, read_data_valid
  );

  modport follower (
    input  read_req, write_req, addr, write_data, byte_enable,
    output read_data, read_data_valid
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-leader bus arbiter: one request slot per leader, alternating tie-break, and an
// in-order FIFO of leader ids that routes each read response back to its issuer.
module bus_arbiter #(
  parameter int Depth = 4
) (
  input  logic clk,
  input  logic reset_n,
  bus.follower leader0,
  bus.follower leader1,
  bus.leader   follower,
  output logic busy0,
  output logic busy1
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;

  logic [1:0]  req_rd, req_wr;
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be [2];

  logic [1:0]  slot_valid, slot_write;
  logic [31:0] slot_addr [2];
  logic [31:0] slot_wdata [2];
  logic [3:0]  slot_be [2];

  logic [1:0]  eligible;
  logic        grant_valid, grant_id, last_grant;

  logic [Depth-1:0] id_mem;
  logic [PtrW-1:0]  wr_ptr, rd_ptr;
  logic [CntW-1:0]  count;
  logic             fifo_full, push, pop, rsp_id;

  assign req_rd    = {leader1.read_req, leader0.read_req};
  assign req_wr    = {leader1.write_req, leader0.write_req};
  assign req_addr[0]  = leader0.addr;
  assign req_addr[1]  = leader1.addr;
  assign req_wdata[0] = leader0.write_data;
  assign req_wdata[1] = leader1.write_data;
  assign req_be[0]    = leader0.byte_enable;
  assign req_be[1]    = leader1.byte_enable;

  assign busy0 = slot_valid[0];
  assign busy1 = slot_valid[1];

  // A request into an occupied slot is dropped; read+write together loads as a write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_valid <= '0;
      slot_write <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (slot_valid[1'(k)]) begin
          if (grant_valid && grant_id == 1'(k)) slot_valid[1'(k)] <= 1'b0;
        end else if (req_rd[1'(k)] || req_wr[1'(k)]) begin
          slot_valid[1'(k)] <= 1'b1;
          slot_write[1'(k)] <= req_wr[1'(k)];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!slot_valid[1'(k)] && (req_rd[1'(k)] || req_wr[1'(k)])) begin
        slot_addr[1'(k)]  <= req_addr[1'(k)];
        slot_wdata[1'(k)] <= req_wdata[1'(k)];
        slot_be[1'(k)]    <= req_be[1'(k)];
      end
    end
  end

  assign fifo_full = (count == CntW'(Depth));
  assign eligible  = slot_valid & (slot_write | {2{~fifo_full}});

  always_comb begin
    grant_valid = |eligible;
    grant_id    = 1'b0;
    if (&eligible) grant_id = ~last_grant;
    else           grant_id = eligible[1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         last_grant <= 1'b1;
    else if (grant_valid) last_grant <= grant_id;
  end

  // With no grant, grant_id is 0 so slot 0 contents appear on the (idle) bus.
  assign follower.addr        = slot_addr[grant_id];
  assign follower.write_data  = slot_wdata[grant_id];
  assign follower.byte_enable = slot_be[grant_id];
  assign follower.read_req    = grant_valid & ~slot_write[grant_id];
  assign follower.write_req   = grant_valid & slot_write[grant_id];

  assign push   = follower.read_req;
  assign pop    = follower.read_data_valid && (count != '0);
  assign rsp_id = id_mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) id_mem[wr_ptr] <= grant_id;
  end

  assign leader0.read_data_valid = pop & ~rsp_id;
  assign leader1.read_data_valid = pop & rsp_id;
  assign leader0.read_data       = follower.read_data;
  assign leader1.read_data       = follower.read_data;

  assert property (@(posedge clk) disable iff (!reset_n)
    !(follower.read_req && follower.write_req));
  assert property (@(posedge clk) disable iff (!reset_n) count <= CntW'(Depth));
  cover property (@(posedge clk) disable iff (!reset_n)
    follower.read_data_valid && count == '0);
  cover property (@(posedge clk) disable iff (!reset_n)
    (slot_valid[0] && (req_rd[0] || req_wr[0])) || (slot_valid[1] && (req_rd[1] || req_wr[1])));

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized and directed bench for bus_arbiter against a queue-based reference model.
module tb_bus_arbiter;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic busy0, busy1;
  int   n_checks = 0;
  int   n_pass   = 0;

  bus l0_if ();
  bus l1_if ();
  bus f_if ();

  bus_arbiter #(.Depth(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .leader0(l0_if), .leader1(l1_if), .follower(f_if),
    .busy0(busy0), .busy1(busy1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } slot_t;

  slot_t      m_slot [2];
  int         m_last;
  logic [0:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic clear_inputs();
    l0_if.read_req = 0; l0_if.write_req = 0;
    l1_if.read_req = 0; l1_if.write_req = 0;
    f_if.read_data_valid = 0;
    f_if.read_data = $urandom();
  endtask

  task automatic model_reset();
    m_slot[0] = '0;
    m_slot[1] = '0;
    m_last = 1;
    exp_q.delete();
  endtask

  task automatic drive(input int k, input bit rd, input bit wr, input logic [31:0] a);
    if (k == 0) begin
      l0_if.read_req = rd; l0_if.write_req = wr; l0_if.addr = a;
      l0_if.write_data = $urandom(); l0_if.byte_enable = 4'($urandom_range(0, 15));
    end else begin
      l1_if.read_req = rd; l1_if.write_req = wr; l1_if.addr = a;
      l1_if.write_data = $urandom(); l1_if.byte_enable = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic respond(input logic [31:0] data);
    f_if.read_data_valid = 1;
    f_if.read_data = data;
  endtask

  // One cycle: inputs already driven after a negedge; check, advance model, next negedge.
  task automatic tick();
    bit   el [2];
    bit   gv, pop, full;
    int   g;
    logic rq [2];
    logic wq [2];
    slot_t ld [2];
    #1;
    rq[0] = l0_if.read_req; wq[0] = l0_if.write_req;
    rq[1] = l1_if.read_req; wq[1] = l1_if.write_req;
    ld[0] = {1'b1, l0_if.write_req, l0_if.addr, l0_if.write_data, l0_if.byte_enable};
    ld[1] = {1'b1, l1_if.write_req, l1_if.addr, l1_if.write_data, l1_if.byte_enable};
    full = (exp_q.size() == DEPTH);
    for (int k = 0; k < 2; k++) el[k] = m_slot[k].v && (m_slot[k].w || !full);
    gv = el[0] || el[1];
    if (el[0] && el[1]) g = 1 - m_last;
    else g = el[1] ? 1 : 0;
    pop = f_if.read_data_valid && exp_q.size() > 0;

    check("busy0", busy0, m_slot[0].v);
    check("busy1", busy1, m_slot[1].v);
    check("f_read_req", f_if.read_req, gv && !m_slot[g].w);
    check("f_write_req", f_if.write_req, gv && m_slot[g].w);
    if (gv) begin
      check("f_addr", f_if.addr, m_slot[g].a);
      check("f_wdata", f_if.write_data, m_slot[g].d);
      check("f_be", 32'(f_if.byte_enable), 32'(m_slot[g].be));
    end
    check("l0_rdv", l0_if.read_data_valid, pop && exp_q[0] == 1'b0);
    check("l1_rdv", l1_if.read_data_valid, pop && exp_q[0] == 1'b1);
    check("l0_rdata", l0_if.read_data, f_if.read_data);
    check("l1_rdata", l1_if.read_data, f_if.read_data);

    if (pop) void'(exp_q.pop_front());
    if (gv) begin
      if (!m_slot[g].w) exp_q.push_back(1'(g));
      m_last = g;
    end
    for (int k = 0; k < 2; k++) begin
      if (m_slot[k].v) begin
        if (gv && g == k) m_slot[k].v = 0;
      end else if (rq[k] || wq[k]) begin
        m_slot[k] = ld[k];
      end
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic do_reset();
    reset_n = 0;
    clear_inputs();
    #1;
    check("rst_busy0", busy0, 0);
    check("rst_busy1", busy1, 0);
    check("rst_f_rd", f_if.read_req, 0);
    check("rst_f_wr", f_if.write_req, 0);
    check("rst_l0_rdv", l0_if.read_data_valid, 0);
    check("rst_l1_rdv", l1_if.read_data_valid, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;
  endtask

  initial begin
    reset_n = 0;
    clear_inputs();
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    @(negedge clk);
    do_reset();

    // Single read: request cycle 0, bus request cycle 1, response cycle 3
    drive(0, 1, 0, 32'h0000_1000); tick();
    #1;
    check("r28_busy0", busy0, 1);
    check("r28_f_rd", f_if.read_req, 1);
    check("r28_addr", f_if.addr, 32'h0000_1000);
    tick();
    tick();
    respond(32'hDEAD_BEEF);
    #1;
    check("r28_l0_rdv", l0_if.read_data_valid, 1);
    check("r28_l1_rdv", l1_if.read_data_valid, 0);
    check("r28_l0_data", l0_if.read_data, 32'hDEAD_BEEF);
    tick();

    // Ties: each pair of simultaneous reads grants leader 0 then leader 1
    do_reset();
    for (int t = 0; t < 4; t++) begin
      drive(0, 1, 0, 32'h100 + t); drive(1, 1, 0, 32'h200 + t); tick();
      #1; check("tie_first", f_if.addr, 32'h100 + t); tick();
      #1; check("tie_second", f_if.addr, 32'h200 + t); tick();
      respond($urandom()); tick();
      respond($urandom()); tick();
    end

    // Full FIFO holds leader 1 read while a leader 0 write proceeds
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 32'h2000 + 4 * i); tick(); tick();
    end
    drive(1, 1, 0, 32'h2010); tick();
    drive(0, 0, 1, 32'h3000);
    #1;
    check("full_busy1", busy1, 1);
    check("full_no_rd", f_if.read_req, 0);
    tick();
    #1;
    check("full_wr", f_if.write_req, 1);
    check("full_wr_addr", f_if.addr, 32'h3000);
    tick();
    respond($urandom());
    #1; check("full_pop_l1", l1_if.read_data_valid, 1);
    tick();
    #1;
    check("held_rd", f_if.read_req, 1);
    check("held_addr", f_if.addr, 32'h2010);
    tick();
    for (int i = 0; i < 4; i++) begin respond($urandom()); tick(); end

    // Push and pop in the same cycle keeps order
    for (int i = 0; i < 3; i++) begin drive(1, 1, 0, 32'h4000 + i); tick(); tick(); end
    drive(0, 1, 0, 32'h5000); tick();
    respond($urandom()); tick();
    for (int i = 0; i < 4; i++) begin respond($urandom()); tick(); end

    // Spurious response with empty FIFO
    respond(32'h1234_5678);
    #1;
    check("spur_l0", l0_if.read_data_valid, 0);
    check("spur_l1", l1_if.read_data_valid, 0);
    tick();
    tick();

    // Reset with two reads outstanding and slot 1 occupied
    drive(0, 1, 0, 32'h6000); tick(); tick();
    drive(0, 1, 0, 32'h6004); tick();
    drive(1, 1, 0, 32'h7000); tick();
    #1;
    check("r33_busy1_pre", busy1, 1);
    do_reset();
    respond($urandom()); tick();
    respond($urandom()); tick();
    drive(0, 1, 0, 32'h8000); drive(1, 1, 0, 32'h9000); tick();
    #1; check("r33_tie_l0", f_if.addr, 32'h8000);
    tick(); tick();

    // Random traffic, with one asynchronous reset midway
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!m_slot[k].v || $urandom_range(0, 7) == 0) begin
          case ($urandom_range(0, 4))
            1: drive(k, 1, 0, $urandom());
            2: drive(k, 0, 1, $urandom());
            3: drive(k, 1, 1, $urandom());
            default: drive(k, 0, 0, $urandom());
          endcase
        end
      end
      if ($urandom_range(0, 2) == 0) respond($urandom());
      if (c == 300) begin
        #2;
        do_reset();
      end else begin
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
